// File: rtl/fleet_placement_ctrl.sv
// fleet_placement_ctrl: sequences both players' 11-ship fleets through the piece validator,
// retrying a ship on conflict or timeout and flagging completion after player 2.
module fleet_placement_ctrl #(
   parameter int SHIPS    = 11,
   parameter int TIMEOUT  = 64,
   parameter int ERR_HOLD = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       confirm,
   input  logic [3:0] x_in,
   input  logic [3:0] y_in,
   input  logic       direcao_in,
   input  logic [2:0] orient_in,
   input  logic       val_ok,
   input  logic       val_conflito,
   output logic       val_enable,
   output logic [2:0] val_tipo,
   output logic [3:0] val_x,
   output logic [3:0] val_y,
   output logic       val_direcao,
   output logic [2:0] val_orient,
   output logic       jogador,
   output logic [3:0] ship_idx,
   output logic       busy,
   output logic       err_conflito,
   output logic       err_timeout,
   output logic       done
);
   localparam int CW = $clog2(TIMEOUT > ERR_HOLD ? TIMEOUT : ERR_HOLD) + 1;
   typedef enum logic [2:0] {IDLE, WAIT_IN, LAUNCH, WAIT_RES, ERROR, NEXT, DONE} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
   logic       jog_q, jog_d, done_q, done_d, errc_q, errc_d, errt_q, errt_d;
   logic [3:0] idx_q, idx_d, vx_q, vx_d, vy_q, vy_d;
   logic       vd_q, vd_d;
   logic [2:0] vo_q, vo_d;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         jog_q   <= 1'b0;
         done_q  <= 1'b0;
         errc_q  <= 1'b0;
         errt_q  <= 1'b0;
         idx_q   <= '0;
         vx_q    <= '0;
         vy_q    <= '0;
         vd_q    <= 1'b0;
         vo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         jog_q   <= jog_d;
         done_q  <= done_d;
         errc_q  <= errc_d;
         errt_q  <= errt_d;
         idx_q   <= idx_d;
         vx_q    <= vx_d;
         vy_q    <= vy_d;
         vd_q    <= vd_d;
         vo_q    <= vo_d;
      end
   end
   // One counter serves both the response timeout and the error hold; it saturates.
   assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      jog_d   = jog_q;
      done_d  = done_q;
      errc_d  = errc_q;
      errt_d  = errt_q;
      idx_d   = idx_q;
      vx_d    = vx_q;
      vy_d    = vy_q;
      vd_d    = vd_q;
      vo_d    = vo_q;
      case (state_q)
         IDLE, DONE: if (start) begin
            state_d = WAIT_IN;
            jog_d   = 1'b0;
            idx_d   = '0;
            done_d  = 1'b0;
         end
         WAIT_IN: if (confirm) begin
            state_d = LAUNCH;
            vx_d    = x_in;
            vy_d    = y_in;
            vd_d    = direcao_in;
            vo_d    = orient_in;
         end
         LAUNCH: begin
            cnt_d   = '0;
            state_d = WAIT_RES;
         end
         WAIT_RES: begin
            cnt_d = cnt_inc;
            if (val_conflito) begin
               state_d = ERROR;
               errc_d  = 1'b1;
               cnt_d   = '0;
            end else if (val_ok) begin
               state_d = NEXT;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               state_d = ERROR;
               errt_d  = 1'b1;
               cnt_d   = '0;
            end
         end
         ERROR: if (cnt_q == CW'(ERR_HOLD - 1)) begin
            state_d = WAIT_IN;
            errc_d  = 1'b0;
            errt_d  = 1'b0;
         end else begin
            cnt_d = cnt_inc;
         end
         NEXT: if (idx_q < 4'(SHIPS - 1)) begin
            idx_d   = idx_q + 4'd1;
            state_d = WAIT_IN;
         end else if (!jog_q) begin
            jog_d   = 1'b1;
            idx_d   = '0;
            state_d = WAIT_IN;
         end else begin
            done_d  = 1'b1;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   // Request strobe is decoded from state so it falls the moment rst rises.
   assign val_enable   = (state_q == LAUNCH) || (state_q == WAIT_RES);
   assign busy         = val_enable;
   assign val_tipo     = idx_q == 4'd0 ? 3'd0 : idx_q <= 4'd2 ? 3'd1 : idx_q <= 4'd4 ? 3'd2 :
                         idx_q <= 4'd7 ? 3'd3 : 3'd4;
   assign val_x        = vx_q;
   assign val_y        = vy_q;
   assign val_direcao  = vd_q;
   assign val_orient   = vo_q;
   assign jogador      = jog_q;
   assign ship_idx     = idx_q;
   assign err_conflito = errc_q;
   assign err_timeout  = errt_q;
   assign done         = done_q;
endmodule

// File: tb/tb_fleet_placement_ctrl.sv
// tb_fleet_placement_ctrl: randomized placement runs checked against a transaction-level
// model of fleet progress (player, index, done, latched coordinates).
module tb_fleet_placement_ctrl;
   logic clk = 0, rst = 1, start = 0, confirm = 0, direcao_in = 0, val_ok = 0, val_conflito = 0;
   logic [3:0] x_in = 0, y_in = 0;
   logic [2:0] orient_in = 0;
   logic val_enable, val_direcao, jogador, busy, err_conflito, err_timeout, done;
   logic [2:0] val_tipo, val_orient;
   logic [3:0] val_x, val_y, ship_idx;
   fleet_placement_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .confirm(confirm), .x_in(x_in), .y_in(y_in),
      .direcao_in(direcao_in), .orient_in(orient_in), .val_ok(val_ok), .val_conflito(val_conflito),
      .val_enable(val_enable), .val_tipo(val_tipo), .val_x(val_x), .val_y(val_y),
      .val_direcao(val_direcao), .val_orient(val_orient), .jogador(jogador), .ship_idx(ship_idx),
      .busy(busy), .err_conflito(err_conflito), .err_timeout(err_timeout), .done(done)
   );
   always #5 clk = ~clk;
   int n_cmp = 0, n_bad = 0;
   int ej = 0, ei = 0, ed = 0;
   logic [3:0] ex = 0, ey = 0;
   logic       edir = 0;
   logic [2:0] eo = 0;
   int tab[11] = '{0, 1, 1, 2, 2, 3, 3, 3, 4, 4, 4};
   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   // oc: 0 ok, 1 conflict, 2 ok+conflict together, 3 silent validator (timeout)
   task automatic do_ship(input int oc, input int xv);
      int n;
      ex = xv < 0 ? 4'($urandom_range(0, 15)) : 4'(xv);
      ey = 4'($urandom_range(0, 15));
      edir = 1'($urandom_range(0, 1));
      eo = 3'($urandom_range(0, 3));
      x_in = ex; y_in = ey; direcao_in = edir; orient_in = eo;
      confirm = 1;
      tick;
      confirm = 0;
      chk("launch_en", val_enable, 1);
      chk("launch_busy", busy, 1);
      chk("val_x", val_x, ex);
      chk("val_y", val_y, ey);
      chk("val_dir", val_direcao, edir);
      chk("val_orient", val_orient, eo);
      chk("val_tipo", val_tipo, tab[ei]);
      chk("jogador", jogador, ej);
      x_in = ~ex; y_in = ~ey; direcao_in = ~edir;
      tick;
      if (oc == 3) begin
         n = 0;
         while (val_enable && n < 100) begin
            n++;
            confirm = (n % 7 == 0);
            tick;
            confirm = 0;
         end
         chk("timeout_cycles", n, 64);
         chk("err_timeout", err_timeout, 1);
         chk("err_conf_on_to", err_conflito, 0);
      end else begin
         repeat ($urandom_range(0, 4)) begin
            chk("wait_en", val_enable, 1);
            confirm = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            tick;
            confirm = 0; start = 0;
         end
         val_ok = (oc != 1);
         val_conflito = (oc != 0);
         tick;
         val_ok = 0; val_conflito = 0;
         chk("resp_en", val_enable, 0);
         chk("resp_busy", busy, 0);
      end
      if (oc == 0) begin
         if (ei < 10) ei++;
         else if (ej == 0) begin ej = 1; ei = 0; end
         else ed = 1;
         tick;
         chk("next_idx", ship_idx, ei);
         chk("next_jog", jogador, ej);
         chk("next_done", done, ed);
         chk("next_tipo", val_tipo, tab[ei]);
         chk("keep_x", val_x, ex);
      end else begin
         chk("err_conflito", err_conflito, int'(oc != 3));
         n = 0;
         while ((err_conflito || err_timeout) && n < 40) begin
            n++;
            if (val_enable) chk("err_en", val_enable, 0);
            confirm = (n % 5 == 0);
            tick;
            confirm = 0;
         end
         chk("hold_cycles", n, 16);
         chk("retry_idx", ship_idx, ei);
         chk("retry_keep_x", val_x, ex);
         chk("retry_en", val_enable, 0);
      end
   endtask
   task automatic do_start;
      start = 1;
      tick;
      start = 0;
      ej = 0; ei = 0; ed = 0;
      chk("start_done", done, 0);
      chk("start_idx", ship_idx, 0);
      chk("start_jog", jogador, 0);
   endtask
   initial begin
      int r, oc;
      repeat (3) tick;
      chk("rst_en", val_enable, 0);
      chk("rst_idx", ship_idx, 0);
      chk("rst_jog", jogador, 0);
      chk("rst_done", done, 0);
      chk("rst_x", val_x, 0);
      chk("rst_errs", {err_conflito, err_timeout}, 0);
      chk("rst_tipo", val_tipo, 0);
      rst = 0;
      confirm = 1;
      tick;
      confirm = 0;
      chk("idle_confirm", val_enable, 0);
      do_start;
      for (int k = 0; k < 22; k++) do_ship(0, -1);
      chk("fleet_done", done, 1);
      repeat (3) begin
         confirm = 1;
         tick;
         confirm = 0;
      end
      chk("done_held", done, 1);
      chk("done_no_req", val_enable, 0);
      do_start;
      do_ship(1, 7);
      do_ship(0, 2);
      chk("after_retry_idx", ship_idx, 1);
      do_ship(3, -1);
      do_ship(2, -1);
      for (int k = 0; k < 200 && ed == 0; k++) begin
         r = $urandom_range(0, 19);
         oc = r < 14 ? 0 : r < 17 ? 1 : r < 19 ? 2 : 3;
         do_ship(oc, -1);
      end
      chk("random_done", done, 1);
      do_start;
      for (int k = 0; k < 20 && !(ej == 1 && ei == 5); k++) do_ship(0, -1);
      confirm = 1;
      tick;
      confirm = 0;
      tick;
      chk("pre_rst_en", val_enable, 1);
      chk("pre_rst_idx", ship_idx, 5);
      #2 rst = 1;
      #1;
      chk("mid_rst_en", val_enable, 0);
      chk("mid_rst_jog", jogador, 0);
      chk("mid_rst_idx", ship_idx, 0);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_x", val_x, 0);
      @(posedge clk);
      #1 rst = 0;
      confirm = 1;
      tick;
      confirm = 0;
      chk("post_rst_idle", val_enable, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
   initial begin
      #5000000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end
endmodule
